load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator-side load/store unit between the execute stage and a word-organised data RAM.
//  Takes one byte/half/word load or store at any byte alignment.
//  Splits a word-crossing access into two aligned beats with byte enables.
//  Reassembles and extends load data, then returns one response per request.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address width; RAM word address is ADDR_WIDTH-2 bits
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high reset
//  req_valid      in   1           core request valid
//  req_ready      out  1           unit can accept a request (state IDLE)
//  req_write      in   1           1 store, 0 load
//  req_addr       in   ADDR_WIDTH  byte address
//  req_size       in   2           00 byte, 01 half, 10 word, 11 illegal
//  req_sign       in   1           load sign-extend (1) / zero-extend (0)
//  req_wdata      in   32          store data, LSB-aligned
//  resp_valid     out  1           one-cycle response pulse
//  resp_rdata     out  32          extended load data; 0 for stores and errors
//  resp_err       out  1           request had req_size==11
//  mem_valid      out  1           RAM beat valid
//  mem_ready      in   1           RAM accepts beat; read data valid same cycle
//  mem_write      out  1           beat is a write
//  mem_word_addr  out  ADDR_WIDTH-2  aligned word address
//  mem_byte_en    out  4           per-byte lane enable
//  mem_wdata      out  32          lane-positioned write data
//  mem_rdata      in   32          full word read data
// BEHAVIOUR
//  - Reset, applied at clk edge: state IDLE.
//    Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0.
//    All captured registers are cleared.
//  - FSM states: IDLE, BEAT0, BEAT1, RESP.
//    - IDLE: req_ready=1. On req_valid, latch write/addr/size/sign/wdata.
//      If size==11, go to RESP with err=1. Otherwise go to BEAT0.
//    - BEAT0: mem_valid=1, word_addr=addr[AW-1:2], off=addr[1:0].
//      mask = 0001/0011/1111 for byte/half/word.
//      byte_en = (mask<<off)[3:0]; wdata = wdata<<(8*off).
//      When mem_ready: capture mem_rdata>>(8*off).
//      Go to BEAT1 if off+nbytes>4, else RESP.
//    - BEAT1: mem_valid=1, word_addr+1, modulo 2^(AW-2) (top word wraps to 0).
//      byte_en = mask>>(4-off); wdata = wdata>>(8*(4-off)).
//      When mem_ready: OR mem_rdata<<(8*(4-off)) into the captured data. Go to RESP.
//    - RESP: resp_valid=1 for exactly one cycle, then IDLE.
//  - Load data: truncate to 8/16 bits, then sign- or zero-extend per req_sign.
//  - Stores: resp_rdata=0. req_sign is ignored for stores.
//  - mem_valid, mem_write, mem_word_addr, mem_byte_en and mem_wdata stay stable
//    while mem_valid=1 and mem_ready=0. mem_ready wait states are unbounded.
//  - Latency with mem_ready=1: aligned access has resp_valid 2 cycles after acceptance.
//    Split access: 3 cycles. Illegal size: 1 cycle, and no mem_valid is ever raised.
//  - Outputs when idle: mem_valid=0 outside BEAT0/BEAT1; beat outputs are don't-care then.
//  - req_ready=0 in BEAT0/BEAT1/RESP; no request is accepted in RESP.
//  - Reset mid-access: the access is abandoned at the edge with no response.
//    A store's first beat may already be written; this is acceptable.
//  - At most one outstanding request.
// TESTING
//  - Store word 0xDEADBEEF @0x004 then load word @0x004, sign=0:
//    one beat each, byte_en=1111, resp_rdata=0xDEADBEEF.
//  - Store byte 0x80 @0x006, then load byte @0x006:
//    sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080; byte_en=0100.
//  - Store word 0x11223344 @0x00B:
//    beat0 word 2 byte_en=1000, beat1 word 3 byte_en=0111.
//    Loading it back gives 0x11223344.
//  - Load half @0x3FF (top word, off=3) with mem holding 0xAB000000 at word 255
//    and 0x000000CD at word 0: beat1 wraps to word 0, sign=1 -> 0xFFFFCDAB.
//  - Insert 3 mem_ready=0 cycles on each beat: beat outputs held stable.
//    Exactly one resp_valid pulse follows.
//  - req_size=11: resp_err=1 next cycle with no mem_valid.
//    Reset asserted in BEAT1: IDLE next cycle with no resp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word access at any byte alignment into one or
// two aligned word beats on a data RAM port, and returns one extended response per request.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_sign_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    resp_valid_o,
    output logic [31:0]             resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic                    mem_write_o,
    output logic [ADDR_WIDTH-3:0]   mem_word_addr_o,
    output logic [3:0]              mem_byte_en_o,
    output logic [31:0]             mem_wdata_o,
    input  logic [31:0]             mem_rdata_i
);

    localparam int unsigned WAW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    state_e      state_q;
    logic        write_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_lane_wdata;
    logic [2:0]  beat1_shift;
    logic [3:0]  beat1_be;
    logic [31:0] beat1_wdata;
    logic        split;
    logic [31:0] beat0_rdata;
    logic [31:0] beat1_rdata;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic sign);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{sign & d[7]}}, d[7:0]};
            2'b01:   r = {{16{sign & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Lane positioning for both beats and the read-data alignment of each beat
    always_comb begin
        req_off        = req_addr_i[1:0];
        req_be         = size_mask(req_size_i) << req_off;
        req_lane_wdata = req_wdata_i << {req_off, 3'b000};
        beat1_shift    = 3'd4 - {1'b0, off_q};
        beat1_be       = size_mask(size_q) >> beat1_shift;
        beat1_wdata    = wdata_q >> {beat1_shift, 3'b000};
        split          = ({1'b0, off_q} + size_bytes(size_q)) > 3'd4;
        beat0_rdata    = mem_rdata_i >> {off_q, 3'b000};
        beat1_rdata    = rdata_q | (mem_rdata_i << {beat1_shift, 3'b000});
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            sign_q          <= 1'b0;
            size_q          <= 2'b00;
            off_q           <= 2'b00;
            wdata_q         <= '0;
            rdata_q         <= '0;
            req_ready_o     <= 1'b1;
            resp_valid_o    <= 1'b0;
            resp_rdata_o    <= '0;
            resp_err_o      <= 1'b0;
            mem_valid_o     <= 1'b0;
            mem_write_o     <= 1'b0;
            mem_word_addr_o <= '0;
            mem_byte_en_o   <= '0;
            mem_wdata_o     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q     <= req_write_i;
                        sign_q      <= req_sign_i;
                        size_q      <= req_size_i;
                        off_q       <= req_off;
                        wdata_q     <= req_wdata_i;
                        rdata_q     <= '0;
                        req_ready_o <= 1'b0;
                        if (req_size_i == 2'b11) begin
                            state_q      <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state_q         <= BEAT0;
                            mem_valid_o     <= 1'b1;
                            mem_write_o     <= req_write_i;
                            mem_word_addr_o <= req_addr_i[ADDR_WIDTH-1:2];
                            mem_byte_en_o   <= req_be;
                            mem_wdata_o     <= req_lane_wdata;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready_i) begin
                        rdata_q <= beat0_rdata;
                        if (split) begin
                            state_q         <= BEAT1;
                            mem_word_addr_o <= mem_word_addr_o + WAW'(1);
                            mem_byte_en_o   <= beat1_be;
                            mem_wdata_o     <= beat1_wdata;
                        end else begin
                            state_q      <= RESP;
                            mem_valid_o  <= 1'b0;
                            resp_valid_o <= 1'b1;
                            resp_rdata_o <= write_q ? '0 : extend(beat0_rdata, size_q, sign_q);
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready_i) begin
                        state_q      <= RESP;
                        mem_valid_o  <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= write_q ? '0 : extend(beat1_rdata, size_q, sign_q);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                    req_ready_o  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
